// File: rtl/vga_timing_pkg.sv
// Shared VGA bus layout macros plus default 1024x768@60 timing constants,
// imported by the timing generator and by downstream drawing stages.
`ifndef VGA_MACROS_SV
`define VGA_MACROS_SV
`define VGA_BUS_SIZE 38
`define VGA_HCOUNT   37:27
`define VGA_VCOUNT   26:16
`define VGA_HS       15
`define VGA_VS       14
`define VGA_HBLNK    13
`define VGA_VBLNK    12
`define VGA_RGB      11:0
`endif

package vga_timing_pkg;

    localparam int CNT_W     = 11;
    localparam int VGA_BUS_W = `VGA_BUS_SIZE;

    localparam int BUS_HC_LSB = 27;
    localparam int BUS_VC_LSB = 16;
    localparam int BUS_HS     = 15;
    localparam int BUS_VS     = 14;
    localparam int BUS_HB     = 13;
    localparam int BUS_VB     = 12;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int H_FP_DEF     = 24;
    localparam int H_SYNC_DEF   = 136;
    localparam int H_BP_DEF     = 160;
    localparam int V_ACTIVE_DEF = 768;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 29;

    // Half-open window test used by the sync decoders.
    function automatic logic in_window(input logic [CNT_W-1:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA timing generator: free-running h/v counters with sync and blank flags,
// all decoded from next-state counters so every bus field lands in the same cycle.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic                     pclk,
    input  logic                     rst,
    output logic [`VGA_BUS_SIZE-1:0] vga_out,
    output logic                     frame_start,
    output logic [15:0]              frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // running is low for the first edge after reset so that edge loads (0,0)
    // instead of advancing, giving the frame_start pulse on release.
    logic             running;
    logic [CNT_W-1:0] hcount, vcount;
    logic [CNT_W-1:0] h_next, v_next;
    logic             hs, vs, hblnk, vblnk;
    logic             hs_next, vs_next, hblnk_next, vblnk_next;
    logic             end_of_line, end_of_frame;

    always_comb begin
        end_of_line  = (hcount == H_LAST);
        end_of_frame = end_of_line && (vcount == V_LAST);
        h_next       = '0;
        v_next       = '0;
        if (running) begin
            h_next = end_of_line ? '0 : hcount + 1'b1;
            if (end_of_line)
                v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
            else
                v_next = vcount;
        end
        hs_next    = in_window(h_next, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
        vs_next    = in_window(v_next, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
        hblnk_next = int'(h_next) >= H_ACTIVE;
        vblnk_next = int'(v_next) >= V_ACTIVE;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            running     <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            running     <= 1'b1;
            hcount      <= h_next;
            vcount      <= v_next;
            hs          <= hs_next;
            vs          <= vs_next;
            hblnk       <= hblnk_next;
            vblnk       <= vblnk_next;
            frame_start <= (h_next == '0) && (v_next == '0);
            if (running && end_of_frame)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_comb begin
        vga_out              = '0;
        vga_out[`VGA_HCOUNT] = hcount;
        vga_out[`VGA_VCOUNT] = vcount;
        vga_out[`VGA_HS]     = hs;
        vga_out[`VGA_VS]     = vs;
        vga_out[`VGA_HBLNK]  = hblnk;
        vga_out[`VGA_VBLNK]  = vblnk;
        vga_out[`VGA_RGB]    = 12'h000;
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-size instance for line timing and a small
// instance for frame-level behaviour, both checked every cycle against a model.
module tb_vga_timing;
    import vga_timing_pkg::*;

    localparam int SHA = 10, SHF = 2, SHS = 3, SHB = 5;
    localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 3;
    localparam int S_HT = SHA + SHF + SHS + SHB;   // 20
    localparam int S_VT = SVA + SVF + SVS + SVB;   // 12
    localparam int S_FL = S_HT * S_VT;             // 240
    localparam int WW   = VGA_BUS_W + 17;

    logic                 pclk = 1'b0;
    logic                 rst  = 1'b1;
    logic [VGA_BUS_W-1:0] vga_big, vga_small;
    logic                 fs_big, fs_small;
    logic [15:0]          fc_big, fc_small;

    int checks = 0;
    int errors = 0;
    int t      = -1;   // cycles since reset release as seen on the bus; -1 = in reset
    int base_s = 0;    // frame count offset for the small instance (after forcing)
    logic chk_en = 1'b0;

    typedef struct {
        int   t;
        int   h;
        int   v;
        logic hs;
        logic hblnk;
    } vec_t;
    vec_t vecs[8];

    vga_timing dut (
        .pclk(pclk), .rst(rst), .vga_out(vga_big),
        .frame_start(fs_big), .frame_cnt(fc_big)
    );

    vga_timing #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_s (
        .pclk(pclk), .rst(rst), .vga_out(vga_small),
        .frame_start(fs_small), .frame_cnt(fc_small)
    );

    always #5 pclk = ~pclk;

    // Reference: bus contents are a pure function of the cycle index since release.
    function automatic logic [WW-1:0] exp_word(input int tt, input int ha, input int hf,
        input int hs, input int hb, input int va, input int vf, input int vs, input int vb,
        input int base);
        int ht, vt, h, v;
        logic hsy, vsy, hbl, vbl, fs;
        logic [10:0] hc, vc;
        logic [15:0] fc;
        if (tt < 0) return '0;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        h   = tt % ht;
        v   = (tt / ht) % vt;
        hsy = (h >= ha + hf) && (h < ha + hf + hs);
        vsy = (v >= va + vf) && (v < va + vf + vs);
        hbl = h >= ha;
        vbl = v >= va;
        fs  = (tt % (ht * vt)) == 0;
        fc  = 16'((base + tt / (ht * vt)) % 65536);
        hc  = 11'(h);
        vc  = 11'(v);
        return {hc, vc, hsy, vsy, hbl, vbl, 12'h000, fs, fc};
    endfunction

    task automatic check_word(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", name, t, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", name, t, act, exp);
        end
    endtask

    function automatic int hc_of(input logic [VGA_BUS_W-1:0] b);
        return int'(b[BUS_HC_LSB +: 11]);
    endfunction

    function automatic int vc_of(input logic [VGA_BUS_W-1:0] b);
        return int'(b[BUS_VC_LSB +: 11]);
    endfunction

    task automatic wait_phase(input int period, input int phase, input int budget);
        int n = 0;
        while ((t < 0 || (t % period) != phase) && n < budget) begin
            @(negedge pclk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_phase timeout period=%0d phase=%0d", period, phase);
        end
    endtask

    always @(posedge pclk) begin
        if (rst) begin
            t      <= -1;
            base_s = 0;
        end else begin
            t <= t + 1;
        end
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            check_word("big_cycle", {vga_big, fs_big, fc_big},
                       exp_word(t, 1024, 24, 136, 160, 768, 3, 6, 29, 0));
            check_word("small_cycle", {vga_small, fs_small, fc_small},
                       exp_word(t, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, base_s));
        end
    end

    initial begin
        int hs_cnt, vs_cnt, fs_cnt;

        vecs[0] = '{1023, 1023, 0, 1'b0, 1'b0};
        vecs[1] = '{1024, 1024, 0, 1'b0, 1'b1};
        vecs[2] = '{1047, 1047, 0, 1'b0, 1'b1};
        vecs[3] = '{1048, 1048, 0, 1'b1, 1'b1};
        vecs[4] = '{1183, 1183, 0, 1'b1, 1'b1};
        vecs[5] = '{1184, 1184, 0, 1'b0, 1'b1};
        vecs[6] = '{1343, 1343, 0, 1'b0, 1'b1};
        vecs[7] = '{1344, 0,    1, 1'b0, 1'b0};

        // Reset held for 5 cycles: everything zero.
        @(posedge pclk);
        #1 chk_en = 1'b1;
        repeat (5) @(negedge pclk);
        check_val("reset_bus_big", int'(vga_big != '0), 0);
        check_val("reset_fs_big", int'(fs_big), 0);
        check_val("reset_fc_small", int'(fc_small), 0);
        rst = 1'b0;

        // First cycle after release.
        @(negedge pclk);
        check_val("rel_h", hc_of(vga_big), 0);
        check_val("rel_v", vc_of(vga_big), 0);
        check_val("rel_fs", int'(fs_big), 1);
        check_val("rel_flags", int'(vga_big[BUS_VB +: 4]), 0);
        check_val("rel_fc", int'(fc_big), 0);

        // Line timing on the default-size instance, table driven.
        hs_cnt = int'(vga_big[BUS_HS]);
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            while (t < vecs[i].t && n < 2000) begin
                @(negedge pclk);
                n++;
                if (t <= 1344) hs_cnt += int'(vga_big[BUS_HS]);
            end
            check_val($sformatf("vec%0d_h", i), hc_of(vga_big), vecs[i].h);
            check_val($sformatf("vec%0d_v", i), vc_of(vga_big), vecs[i].v);
            check_val($sformatf("vec%0d_hs", i), int'(vga_big[BUS_HS]), int'(vecs[i].hs));
            check_val($sformatf("vec%0d_hblnk", i), int'(vga_big[BUS_HB]), int'(vecs[i].hblnk));
        end
        check_val("hs_width_line0", hs_cnt, 136);

        // Mid-frame reset on the small instance at (5,3).
        wait_phase(S_FL, 3 * S_HT + 5, 400);
        check_val("pre_rst_h", hc_of(vga_small), 5);
        check_val("pre_rst_v", vc_of(vga_small), 3);
        rst = 1'b1;
        @(negedge pclk);
        check_val("mid_rst_bus", int'(vga_small != '0), 0);
        check_val("mid_rst_fc", int'(fc_small), 0);
        check_val("mid_rst_fs", int'(fs_small), 0);
        rst = 1'b0;
        @(negedge pclk);
        check_val("post_rst_h", hc_of(vga_small), 0);
        check_val("post_rst_v", vc_of(vga_small), 0);
        check_val("post_rst_fs", int'(fs_small), 1);
        check_val("post_rst_fc", int'(fc_small), 0);

        // Two full small frames.
        vs_cnt = 0;
        fs_cnt = 0;
        repeat (2 * S_FL) begin
            @(negedge pclk);
            vs_cnt += int'(vga_small[BUS_VS]);
            fs_cnt += int'(fs_small);
        end
        check_val("two_frames_fc", int'(fc_small), 2);
        check_val("two_frames_fs", fs_cnt, 2);
        check_val("two_frames_vs", vs_cnt, 2 * SVS * S_HT);

        // Frame counter wrap: preload 16'hFFFF mid-frame.
        wait_phase(S_FL, 200, 400);
        @(posedge pclk);
        #2;
        force dut_s.frame_cnt = 16'hFFFF;
        base_s = 65535 - t / S_FL;
        #1 release dut_s.frame_cnt;
        wait_phase(S_FL, S_FL - 1, 400);
        check_val("pre_wrap_fc", int'(fc_small), 16'hFFFF);
        @(negedge pclk);
        check_val("wrap_fc", int'(fc_small), 0);
        check_val("wrap_h", hc_of(vga_small), 0);
        check_val("wrap_v", vc_of(vga_small), 0);
        check_val("wrap_fs", int'(fs_small), 1);

        // Random run lengths and reset pulses; the per-cycle model checks all of it.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 500)) @(negedge pclk);
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge pclk);
            rst = 1'b0;
        end
        repeat ($urandom_range(S_FL, 2 * S_FL)) @(negedge pclk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 160, horizontal back porch in pixels; H_TOTAL = sum of the four = 1344.
REQ-005 SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 SHALL have parameters V_FP=3, V_SYNC=6, V_BP=29, vertical porches/sync in lines; V_TOTAL = 806.
REQ-007 SHALL have port pclk, input, 1, pixel clock (65 MHz); the block's one clock, rising edge only.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port vga_out, output, `VGA_BUS_SIZE, timing bus carrying hcount, vcount, hs, vs, hblnk, vblnk and rgb in the shared bus layout.
REQ-010 SHALL have port frame_start, output, 1, one-cycle pulse on the first pixel (0,0) of every frame.
REQ-011 SHALL have port frame_cnt, output, 16, number of completed frames since reset.

Function
REQ-012 hcount SHALL increment by 1 per pclk, from 0 to H_TOTAL-1, then wrap to 0.
REQ-013 vcount SHALL increment by 1 only in the cycle hcount wraps, from 0 to V_TOTAL-1, then wrap to 0 together with hcount.
REQ-014 hblnk SHALL be 1 iff hcount >= H_ACTIVE; vblnk SHALL be 1 iff vcount >= V_ACTIVE.
REQ-015 hs SHALL be 1 (active-high on the bus) iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183 at defaults.
REQ-016 vs SHALL be 1 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776 at defaults.
REQ-017 Every bus field SHALL be registered and mutually consistent: hs/vs/hblnk/vblnk in a cycle SHALL be the decode of the hcount/vcount shown in that same cycle, with no skew.
REQ-018 The rgb field SHALL be driven constant 12'h000.
REQ-019 frame_start SHALL be 1 exactly in the cycle the bus shows hcount=0 and vcount=0, and 0 otherwise.
REQ-020 frame_cnt SHALL increment by 1 in the cycle after the bus shows (H_TOTAL-1, V_TOTAL-1), i.e. aligned with frame_start, and SHALL wrap 16'hFFFF -> 0.
REQ-021 Counter widths SHALL be 11 bits, so defaults up to 2047 fit; no carry out of range is permitted.

Reset
REQ-022 While rst=1 at a pclk edge, hcount, vcount, hs, vs, hblnk, vblnk, rgb and frame_cnt SHALL be 0 at the next edge, and frame_start SHALL be 0.
REQ-023 In the first cycle after rst falls, the bus SHALL show (0,0) and frame_start SHALL be 1; frame_cnt SHALL remain 0.
REQ-024 Reset asserted mid-line or mid-frame SHALL abandon the frame without incrementing frame_cnt.

Structure
REQ-025 Bus width and field slices SHALL come from the shared VGA macro header; default 1024x768 timing constants SHALL live in a shared package/header so that drawing stages can use H_ACTIVE and V_ACTIVE.
REQ-026 The design SHALL be a single module with no sub-modules; the two sync/blank decoders SHALL be combinational on next-state counters, feeding output registers.

Verification
REQ-027 Release rst after 5 cycles -> first post-reset cycle shows hcount=0, vcount=0, frame_start=1, hs=vs=hblnk=vblnk=0.
REQ-028 Run 1344 cycles from (0,0) -> hcount reaches 1343 with vcount=0, then shows (0,1); hblnk rises at hcount=1024; hs high for exactly 136 cycles starting at 1048.
REQ-029 Run 2 full frames (2*1344*806 cycles) -> frame_cnt=2, exactly 2 frame_start pulses after the initial one; vs high for 6*1344 cycles per frame starting at vcount=771, hcount=0.
REQ-030 Assert rst at hcount=500, vcount=300 for 1 cycle -> next cycle bus all-zero, frame_cnt=0; cycle after release shows (0,0) with frame_start=1.
REQ-031 Force frame_cnt to 16'hFFFF (or run with reduced V_TOTAL=4, H_TOTAL=8 override) -> next frame boundary wraps frame_cnt to 0 without disturbing hcount/vcount.
REQ-032 Every cycle, the checker SHALL recompute hs/vs/hblnk/vblnk from the bus hcount/vcount -> zero mismatches over 2 frames.
